// File: rtl/idecode_q.sv
// Decode-stage instruction queue: DEPTH-entry ring buffer with valid/ready on both sides,
// synchronous flush and combinational decode of the head entry. Optional macro: IDQ_BYPASS_EN.
module idecode_q #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = 32,
    parameter int unsigned PW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IW-1:0]            in_instr,
    input  logic [PW-1:0]            in_pc8,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               cond_d,
    output logic [3:0]               rd_d,
    output logic [3:0]               ra1,
    output logic [3:0]               ra2,
    output logic [3:0]               rs_d,
    output logic [31:0]              ext_imm,
    output logic                     is_dp,
    output logic                     is_mem,
    output logic                     is_br,
    output logic                     undef,
    output logic                     link,
    output logic [PW-1:0]            pc8_d,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [IW-1:0] instr_mem_q [DEPTH];
    logic [PW-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          empty_c;
    logic          byp_c;
    logic          push_c;
    logic          pop_c;
    logic [31:0]   instr_c;
    logic [PW-1:0] pc_c;
    logic [1:0]    cls_c;
    logic          unused_c;

    assign empty_c   = (count_q == '0);
    assign in_ready  = (count_q != CW'(DEPTH));
    assign count     = count_q;

    // Bypass hands an arriving word straight to decode while the queue is empty
`ifdef IDQ_BYPASS_EN
    assign byp_c     = empty_c & in_valid & ~flush;
    assign instr_c   = empty_c ? 32'(in_instr) : 32'(instr_mem_q[rd_ptr_q]);
    assign pc_c      = empty_c ? in_pc8 : pc_mem_q[rd_ptr_q];
`else
    assign byp_c     = 1'b0;
    assign instr_c   = 32'(instr_mem_q[rd_ptr_q]);
    assign pc_c      = pc_mem_q[rd_ptr_q];
`endif

    assign out_valid = ~flush & (~empty_c | byp_c);
    assign pop_c     = out_valid & out_ready & ~empty_c;
    assign push_c    = in_valid & in_ready & ~flush & ~(byp_c & out_ready);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc8;
        end
    end

    assign cls_c    = instr_c[27:26];
    assign unused_c = instr_c[25];

    always_comb begin
        cond_d  = '0;
        rd_d    = '0;
        ra1     = '0;
        ra2     = '0;
        rs_d    = '0;
        ext_imm = '0;
        is_dp   = 1'b0;
        is_mem  = 1'b0;
        is_br   = 1'b0;
        undef   = 1'b0;
        link    = 1'b0;
        pc8_d   = '0;
        if (out_valid) begin
            cond_d = instr_c[31:28];
            rd_d   = instr_c[15:12];
            rs_d   = instr_c[11:8];
            pc8_d  = pc_c;
            is_dp  = (cls_c == 2'b00);
            is_mem = (cls_c == 2'b01);
            is_br  = (cls_c == 2'b10);
            undef  = (cls_c == 2'b11);
            link   = is_br & instr_c[24];
            ra1    = is_br ? 4'hF : instr_c[19:16];
            ra2    = (is_mem & ~instr_c[20]) ? instr_c[15:12] : instr_c[3:0];
            case (cls_c)
                2'b00:   ext_imm = {24'd0, instr_c[7:0]};
                2'b01:   ext_imm = {20'd0, instr_c[11:0]};
                2'b10:   ext_imm = {{6{instr_c[23]}}, instr_c[23:0], 2'b00};
                default: ext_imm = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_idecode_q.sv
// Scoreboard bench for idecode_q: directed words with hand-decoded expectations.
module tb_idecode_q;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  rd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  rs;
        logic [31:0] imm;
        logic        dp;
        logic        mem;
        logic        br;
        logic        und;
        logic        lnk;
        logic [31:0] pc8;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_instr, in_pc8;
    logic [3:0]    cond_d, rd_d, ra1, ra2, rs_d;
    logic [31:0]   ext_imm, pc8_d;
    logic          is_dp, is_mem, is_br, undef, link;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    idecode_q #(.DEPTH(DEPTH), .IW(32), .PW(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc8(in_pc8),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .cond_d(cond_d), .rd_d(rd_d), .ra1(ra1), .ra2(ra2), .rs_d(rs_d), .ext_imm(ext_imm),
        .is_dp(is_dp), .is_mem(is_mem), .is_br(is_br), .undef(undef), .link(link),
        .pc8_d(pc8_d), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [3:0] cond, input logic [3:0] rd, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] rs, input logic [31:0] imm,
                                input logic [3:0] cls, input logic lnk, input logic [31:0] pc);
        exp_t e;
        e.cond = cond; e.rd = rd; e.ra1 = a1; e.ra2 = a2; e.rs = rs; e.imm = imm;
        {e.dp, e.mem, e.br, e.und} = cls;
        e.lnk = lnk; e.pc8 = pc;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake on the output side retires the oldest expectation
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            exp_t act;
            act = '{cond: cond_d, rd: rd_d, ra1: ra1, ra2: ra2, rs: rs_d, imm: ext_imm,
                    dp: is_dp, mem: is_mem, br: is_br, und: undef, lnk: link, pc8: pc8_d};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: actual=%0h required=none", act);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL decode: actual=%0h required=%0h", act, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic [31:0] pc, input exp_t e, input bit expect_out);
        bit acc;
        in_valid = 1'b1;
        in_instr = w;
        in_pc8   = pc;
        if (expect_out) sb.push_back(e);
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: actual=not_accepted required=accepted word=%0h", w);
        end
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 50 && count != '0; n++) @(posedge clk);
        #1;
        check("drain_count", 64'(count), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc8 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_decoded", {ext_imm, cond_d, rd_d, ra1, ra2, rs_d, is_dp, is_mem, is_br, undef},
              64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD R1,R2,#5: latency check on an empty queue with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hE282_1005;
        in_pc8    = 32'h100;
        sb.push_back(mk(4'hE, 4'h1, 4'h2, 4'h5, 4'h0, 32'h5, 4'b1000, 1'b0, 32'h100));
        @(negedge clk);
`ifdef IDQ_BYPASS_EN
        check("lat_same_cycle", 64'(out_valid), 64'd1);
`else
        check("lat_same_cycle", 64'(out_valid), 64'd0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef IDQ_BYPASS_EN
        check("lat_count", 64'(count), 64'd0);
`else
        check("lat_count", 64'(count), 64'd1);
        @(negedge clk);
        check("lat_next_cycle", 64'(out_valid), 64'd1);
`endif
        @(posedge clk);
        #1;
        check("add_count_after_pop", 64'(count), 64'd0);

        // Branches, memory and undefined class back to back
        send(32'hEB00_0004, 32'h108, mk(4'hE, 4'h0, 4'hF, 4'h4, 4'h0, 32'h10,       4'b0010, 1'b1, 32'h108), 1'b1);
        send(32'hEAFF_FFFE, 32'h10C, mk(4'hE, 4'hF, 4'hF, 4'hE, 4'hF, 32'hFFFF_FFF8, 4'b0010, 1'b0, 32'h10C), 1'b1);
        send(32'hE584_3008, 32'h110, mk(4'hE, 4'h3, 4'h4, 4'h3, 4'h0, 32'h8,        4'b0100, 1'b0, 32'h110), 1'b1);
        send(32'hE594_3008, 32'h114, mk(4'hE, 4'h3, 4'h4, 4'h8, 4'h0, 32'h8,        4'b0100, 1'b0, 32'h114), 1'b1);
        send(32'hEC12_3456, 32'h118, mk(4'hE, 4'h3, 4'h2, 4'h6, 4'h4, 32'h0,        4'b0001, 1'b0, 32'h118), 1'b1);
        wait_empty();

        // Fill to DEPTH with out_ready low, then release and drain in order
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'hE3A0_0000 | (32'h11 * 32'(i + 1));
            send(w, 32'h200 + 32'(4 * i),
                 mk(4'hE, 4'h0, 4'h0, w[3:0], 4'h0, {24'd0, w[7:0]}, 4'b1000, 1'b0, 32'h200 + 32'(4 * i)), 1'b1);
        end
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        fork
            begin
                w = 32'hE3A0_0000 | (32'h11 * 32'(DEPTH + 1));
                send(w, 32'h300, mk(4'hE, 4'h0, 4'h0, w[3:0], 4'h0, {24'd0, w[7:0]}, 4'b1000, 1'b0, 32'h300), 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("full_hold_count", 64'(count), 64'(DEPTH));
                check("full_hold_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Flush with two entries queued and a word offered in the same cycle
        out_ready = 1'b0;
        send(32'hE3A0_00AA, 32'h400, '0, 1'b0);
        send(32'hE3A0_00AB, 32'h404, '0, 1'b0);
        check("pre_flush_count", 64'(count), 64'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hE3A0_00BB;
        in_pc8   = 32'h408;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("post_flush_count", 64'(count), 64'd0);
        check("post_flush_out_valid", 64'(out_valid), 64'd0);
        send(32'hE3A0_00CC, 32'h40C, mk(4'hE, 4'h0, 4'h0, 4'hC, 4'h0, 32'hCC, 4'b1000, 1'b0, 32'h40C), 1'b1);
        wait_empty();

        // Asynchronous reset mid-stream drops queued entries
        out_ready = 1'b0;
        send(32'hE3A0_00D1, 32'h500, '0, 1'b0);
        send(32'hE3A0_00D2, 32'h504, '0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        send(32'h0281_1007, 32'h508, mk(4'h0, 4'h1, 4'h1, 4'h7, 4'h0, 32'h7, 4'b1000, 1'b0, 32'h508), 1'b1);
        wait_empty();

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
